// File: rtl/eth_pkg.sv
// Shared Ethernet constants, TX state encoding and the byte-wide CRC-32 step
// used by the GMII transmit MAC and the byte-capture receiver.
`timescale 1ns/1ps
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam int unsigned ETH_MIN_LEN     = 60;
    localparam logic [31:0] ETH_CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg,
        StDrop
    } tx_state_e;

    // One byte of the reflected CRC-32, LSB of the byte processed first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide CRC-32 register; init has priority over en. The raw register is
// exposed so a receiver can compare it against the residue after the FCS.
`timescale 1ns/1ps
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    always_ff @(posedge clock) begin
        if (reset || init) begin
            crc <= ETH_CRC_INIT;
        end else if (en) begin
            crc <= crc32_byte(crc, data);
        end
    end

endmodule

// File: rtl/eth_gmii_tx.sv
// GMII transmit MAC: preamble/SFD, minimum-size padding, CRC-32 FCS and
// inter-frame gap, with underrun/oversize abort signalled via TX_ER.
`timescale 1ns/1ps
module eth_gmii_tx
    import eth_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 1514,
    parameter int unsigned IFG_BYTES = 12
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       phy_tx_en,
    output logic       phy_tx_er,
    output logic [7:0] phy_tx_data,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_abort
);

    localparam logic [10:0] MinLen  = 11'(ETH_MIN_LEN);
    localparam logic [10:0] MaxLen  = 11'(MAX_LEN);
    localparam logic [15:0] PreLast = 16'd5;
    localparam logic [15:0] FcsLast = 16'd3;
    localparam logic [15:0] IfgLast = 16'(IFG_BYTES - 1);

    tx_state_e   state_q;
    logic [15:0] step_q;
    logic [10:0] byte_cnt_q;
    logic [10:0] byte_cnt_inc;
    logic        oversize;
    logic        crc_init;
    logic        crc_en;
    logic [7:0]  crc_data;
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [7:0]  fcs_byte;

    assign in_ready = (state_q == StData) || (state_q == StDrop);
    assign busy     = (state_q != StIdle);

    always_comb begin
        byte_cnt_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
        oversize     = (byte_cnt_q == MaxLen) && !in_last;
    end

    // CRC restarts while the SFD is being queued so it covers data and pad only.
    always_comb begin
        crc_init = (state_q == StSfd);
        crc_en   = ((state_q == StData) && in_valid && !oversize) || (state_q == StPad);
        crc_data = (state_q == StPad) ? 8'h00 : in_data;
    end

    eth_crc32 u_crc (
        .clock (clock),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .data  (crc_data),
        .crc   (crc)
    );

    assign fcs = ~crc;

    always_comb begin
        fcs_byte = fcs[7:0];
        unique case (step_q[1:0])
            2'd0: fcs_byte = fcs[7:0];
            2'd1: fcs_byte = fcs[15:8];
            2'd2: fcs_byte = fcs[23:16];
            2'd3: fcs_byte = fcs[31:24];
            default: fcs_byte = fcs[7:0];
        endcase
    end

    // Each state registers the byte that appears on TXD in the following cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            step_q      <= '0;
            byte_cnt_q  <= '0;
            phy_tx_en   <= 1'b0;
            phy_tx_er   <= 1'b0;
            phy_tx_data <= 8'h00;
            tx_done     <= 1'b0;
            tx_abort    <= 1'b0;
        end else begin
            tx_done   <= 1'b0;
            tx_abort  <= 1'b0;
            phy_tx_er <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    phy_tx_en   <= 1'b0;
                    phy_tx_data <= 8'h00;
                    if (in_valid) begin
                        state_q     <= StPre;
                        step_q      <= '0;
                        phy_tx_en   <= 1'b1;
                        phy_tx_data <= ETH_PREAMBLE;
                    end
                end
                StPre: begin
                    phy_tx_en   <= 1'b1;
                    phy_tx_data <= ETH_PREAMBLE;
                    if (step_q == PreLast) begin
                        state_q <= StSfd;
                    end else begin
                        step_q <= step_q + 16'd1;
                    end
                end
                StSfd: begin
                    phy_tx_en   <= 1'b1;
                    phy_tx_data <= ETH_SFD;
                    byte_cnt_q  <= '0;
                    state_q     <= StData;
                end
                StData: begin
                    if (!in_valid || oversize) begin
                        phy_tx_en   <= 1'b1;
                        phy_tx_er   <= 1'b1;
                        phy_tx_data <= 8'h00;
                        tx_abort    <= 1'b1;
                        state_q     <= StDrop;
                    end else begin
                        phy_tx_en   <= 1'b1;
                        phy_tx_data <= in_data;
                        byte_cnt_q  <= byte_cnt_inc;
                        if (in_last) begin
                            step_q  <= '0;
                            state_q <= (byte_cnt_inc < MinLen) ? StPad : StFcs;
                        end
                    end
                end
                StPad: begin
                    phy_tx_en   <= 1'b1;
                    phy_tx_data <= 8'h00;
                    byte_cnt_q  <= byte_cnt_inc;
                    if (byte_cnt_inc >= MinLen) begin
                        step_q  <= '0;
                        state_q <= StFcs;
                    end
                end
                StFcs: begin
                    phy_tx_en   <= 1'b1;
                    phy_tx_data <= fcs_byte;
                    if (step_q == FcsLast) begin
                        tx_done <= 1'b1;
                        step_q  <= '0;
                        state_q <= StIfg;
                    end else begin
                        step_q <= step_q + 16'd1;
                    end
                end
                StIfg: begin
                    phy_tx_en   <= 1'b0;
                    phy_tx_data <= 8'h00;
                    if (step_q >= IfgLast) begin
                        state_q <= StIdle;
                    end else begin
                        step_q <= step_q + 16'd1;
                    end
                end
                StDrop: begin
                    phy_tx_en   <= 1'b0;
                    phy_tx_data <= 8'h00;
                    if (in_valid && in_last) begin
                        step_q  <= '0;
                        state_q <= StIfg;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_gmii_tx.sv
// Directed bench for eth_gmii_tx and eth_crc32: framing, padding, FCS, IFG,
// underrun, oversize and mid-frame reset.
`timescale 1ns/1ps
module tb_eth_gmii_tx;
    import eth_pkg::*;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data  = 8'h00;
    logic        in_last  = 1'b0;
    logic        in_ready;
    logic        phy_tx_en;
    logic        phy_tx_er;
    logic [7:0]  phy_tx_data;
    logic        busy;
    logic        tx_done;
    logic        tx_abort;

    logic        crc_init = 1'b0;
    logic        crc_en   = 1'b0;
    logic [7:0]  crc_data = 8'h00;
    logic [31:0] crc_out;

    always #4 clock = ~clock;

    eth_gmii_tx #(
        .MAX_LEN   (1514),
        .IFG_BYTES (12)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .phy_tx_en   (phy_tx_en),
        .phy_tx_er   (phy_tx_er),
        .phy_tx_data (phy_tx_data),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_abort    (tx_abort)
    );

    eth_crc32 u_crc (
        .clock (clock),
        .reset (reset),
        .init  (crc_init),
        .en    (crc_en),
        .data  (crc_data),
        .crc   (crc_out)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] cap[$];
    int         rise_q[$];
    int         fall_q[$];
    int         en_cnt, er_cnt, done_cnt, abort_cnt, rdy_cnt;
    int         done_cyc, er_cyc, abort_cyc;
    logic       prev_en = 1'b0;

    always @(negedge clock) begin
        if (phy_tx_en) begin
            cap.push_back(phy_tx_data);
            en_cnt++;
            if (!prev_en) rise_q.push_back(cyc);
        end
        if (prev_en && !phy_tx_en) fall_q.push_back(cyc - 1);
        prev_en = phy_tx_en;
        if (phy_tx_er) begin er_cnt++; er_cyc = cyc; end
        if (tx_done) begin done_cnt++; done_cyc = cyc; end
        if (tx_abort) begin abort_cnt++; abort_cyc = cyc; end
        if (in_ready) rdy_cnt++;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pat(input int seed, input int k);
        return 8'(seed * 37 + k * 11 + (k >> 3));
    endfunction

    // Bit-serial reference CRC, data LSB first.
    function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        b;
        r = c;
        for (int i = 0; i < 8; i++) begin
            b = r[0] ^ d[i];
            r = r >> 1;
            if (b) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_fcs(input int seed, input int len);
        logic [31:0] c;
        int          n;
        c = 32'hFFFFFFFF;
        n = (len < 60) ? 60 : len;
        for (int k = 0; k < n; k++) c = ref_crc(c, (k < len) ? pat(seed, k) : 8'h00);
        return ~c;
    endfunction

    task automatic clear_mon();
        cap.delete();
        rise_q.delete();
        fall_q.delete();
        en_cnt = 0; er_cnt = 0; done_cnt = 0; abort_cnt = 0; rdy_cnt = 0;
        done_cyc = -1; er_cyc = -1; abort_cyc = -1;
    endtask

    // Presents bytes of pattern 'seed'; drop_at inserts one in_valid=0 cycle,
    // stop_at returns early with in_valid still high.
    task automatic drive(input int len, input int seed, input int drop_at, input int stop_at,
                         input bit keep, output int acc_cyc);
        int k = 0;
        int guard = 0;
        bit dropped = 0;
        bit acc;
        acc_cyc  = -1;
        in_valid = 1'b1;
        in_data  = pat(seed, 0);
        in_last  = (len == 1);
        while (k < len && k != stop_at && guard < len + 300) begin
            guard++;
            if (k == drop_at && !dropped) begin
                dropped  = 1;
                in_valid = 1'b0;
                @(posedge clock); #1;
                in_valid = 1'b1;
                continue;
            end
            @(negedge clock);
            acc = in_ready;
            if (acc) acc_cyc = cyc;
            @(posedge clock); #1;
            if (acc) begin
                k++;
                if (k < len) begin
                    in_data = pat(seed, k);
                    in_last = (k == len - 1);
                end
            end
        end
        checks++;
        if (k != len && k != stop_at) begin
            failures++;
            $display("FAIL drive_timeout: accepted %0d bytes, required %0d", k, len);
        end
        if (!keep && k == len) begin
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic wait_idle(output int idle_cyc);
        int g = 0;
        idle_cyc = -1;
        while (g < 400) begin
            @(negedge clock);
            if (!busy) begin
                idle_cyc = cyc;
                break;
            end
            g++;
        end
        checks++;
        if (idle_cyc < 0) begin
            failures++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", g);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if ({phy_tx_en, phy_tx_er, busy, tx_done, tx_abort, in_ready} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: en/er/busy/done/abort/ready=%b required 000000",
                     {phy_tx_en, phy_tx_er, busy, tx_done, tx_abort, in_ready});
        end
        checks++;
        if (phy_tx_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: txd=%h required 00", phy_tx_data);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_crc_unit();
        string s = "123456789";
        crc_init = 1'b1;
        @(posedge clock); #1;
        crc_init = 1'b0;
        for (int i = 0; i < 9; i++) begin
            crc_en   = 1'b1;
            crc_data = s[i];
            @(posedge clock); #1;
        end
        crc_en = 1'b0;
        @(negedge clock);
        checks++;
        if (~crc_out !== 32'hCBF43926) begin
            failures++;
            $display("FAIL crc_check: ~crc=%h required cbf43926", ~crc_out);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_frame64();
        int t0, acc, idle, bad;
        logic [31:0] exp_fcs, got_fcs, r;
        clear_mon();
        t0 = cyc;
        drive(64, 1, -1, -1, 0, acc);
        wait_idle(idle);
        exp_fcs = model_fcs(1, 64);
        checks++;
        if (en_cnt != 76) begin
            failures++; $display("FAIL f64_en_len: %0d cycles, required 76", en_cnt);
        end
        checks++;
        if (rise_q.size() != 1 || rise_q[0] != t0 + 1) begin
            failures++; $display("FAIL f64_rise: rise=%0d required %0d", rise_q[0], t0 + 1);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) if (cap[i] !== ((i == 7) ? 8'hD5 : 8'h55)) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL f64_preamble: %0d bad bytes, required 0", bad);
        end
        bad = 0;
        for (int k = 0; k < 64; k++) if (cap[8 + k] !== pat(1, k)) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL f64_payload: %0d bad bytes, required 0", bad);
        end
        got_fcs = {cap[75], cap[74], cap[73], cap[72]};
        checks++;
        if (got_fcs !== exp_fcs) begin
            failures++; $display("FAIL f64_fcs: %h required %h", got_fcs, exp_fcs);
        end
        r = 32'hFFFFFFFF;
        for (int i = 8; i < 76; i++) r = ref_crc(r, cap[i]);
        checks++;
        if (r !== ETH_CRC_RESIDUE) begin
            failures++; $display("FAIL f64_residue: %h required %h", r, ETH_CRC_RESIDUE);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != t0 + 76) begin
            failures++;
            $display("FAIL f64_done: count=%0d cyc=%0d required 1 at %0d", done_cnt, done_cyc,
                     t0 + 76);
        end
        checks++;
        if (er_cnt != 0 || abort_cnt != 0) begin
            failures++; $display("FAIL f64_err: er=%0d abort=%0d required 0", er_cnt, abort_cnt);
        end
        checks++;
        if (idle != t0 + 88) begin
            failures++; $display("FAIL f64_busy_end: idle at %0d required %0d", idle, t0 + 88);
        end
    endtask

    task automatic test_short_frame();
        int t0, acc, idle, bad;
        logic [31:0] exp_fcs, got_fcs;
        clear_mon();
        t0 = cyc;
        drive(14, 2, -1, -1, 0, acc);
        wait_idle(idle);
        exp_fcs = model_fcs(2, 14);
        checks++;
        if (en_cnt != 72) begin
            failures++; $display("FAIL short_en_len: %0d cycles, required 72", en_cnt);
        end
        checks++;
        if (rdy_cnt != 14) begin
            failures++; $display("FAIL short_ready: %0d cycles, required 14", rdy_cnt);
        end
        bad = 0;
        for (int k = 0; k < 60; k++) if (cap[8 + k] !== ((k < 14) ? pat(2, k) : 8'h00)) bad++;
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL short_pad: %0d bad bytes, required 0", bad);
        end
        got_fcs = {cap[71], cap[70], cap[69], cap[68]};
        checks++;
        if (got_fcs !== exp_fcs) begin
            failures++; $display("FAIL short_fcs: %h required %h", got_fcs, exp_fcs);
        end
        checks++;
        if (done_cyc != t0 + 72) begin
            failures++; $display("FAIL short_done: cyc=%0d required %0d", done_cyc, t0 + 72);
        end
    endtask

    task automatic test_back_to_back();
        int acc, idle, gap;
        logic [31:0] exp_fcs, got_fcs;
        clear_mon();
        drive(60, 3, -1, -1, 1, acc);
        drive(61, 4, -1, -1, 0, acc);
        wait_idle(idle);
        checks++;
        if (rise_q.size() != 2 || fall_q.size() != 2) begin
            failures++;
            $display("FAIL b2b_frames: rises=%0d falls=%0d required 2", rise_q.size(), fall_q.size());
        end else begin
            gap = rise_q[1] - fall_q[0] - 1;
            checks++;
            if (gap != 12) begin
                failures++; $display("FAIL b2b_ifg: gap=%0d required 12", gap);
            end
        end
        checks++;
        if (en_cnt != 145 || done_cnt != 2) begin
            failures++;
            $display("FAIL b2b_len: en=%0d done=%0d required 145 and 2", en_cnt, done_cnt);
        end
        exp_fcs = model_fcs(4, 61);
        got_fcs = {cap[144], cap[143], cap[142], cap[141]};
        checks++;
        if (got_fcs !== exp_fcs) begin
            failures++; $display("FAIL b2b_fcs2: %h required %h", got_fcs, exp_fcs);
        end
    endtask

    task automatic test_underrun();
        int t0, acc, idle;
        clear_mon();
        t0 = cyc;
        drive(40, 5, 20, -1, 0, acc);
        wait_idle(idle);
        checks++;
        if (er_cnt != 1 || er_cyc != t0 + 29) begin
            failures++;
            $display("FAIL ur_er: count=%0d cyc=%0d required 1 at %0d", er_cnt, er_cyc, t0 + 29);
        end
        checks++;
        if (abort_cnt != 1 || abort_cyc != t0 + 29 || done_cnt != 0) begin
            failures++;
            $display("FAIL ur_abort: abort=%0d cyc=%0d done=%0d required 1 at %0d, done 0",
                     abort_cnt, abort_cyc, done_cnt, t0 + 29);
        end
        checks++;
        if (en_cnt != 29 || cap[28] !== 8'h00) begin
            failures++;
            $display("FAIL ur_no_fcs: en=%0d last=%h required 29 and 00", en_cnt, cap[28]);
        end
        checks++;
        if (idle != acc + 13) begin
            failures++; $display("FAIL ur_ifg: idle at %0d required %0d", idle, acc + 13);
        end
    endtask

    task automatic test_oversize();
        int t0, acc, idle;
        clear_mon();
        t0 = cyc;
        drive(1516, 8, -1, -1, 0, acc);
        wait_idle(idle);
        checks++;
        if (er_cnt != 1 || abort_cnt != 1 || done_cnt != 0 || er_cyc != t0 + 1523) begin
            failures++;
            $display("FAIL ovs_abort: er=%0d abort=%0d done=%0d er_cyc=%0d required 1/1/0 at %0d",
                     er_cnt, abort_cnt, done_cnt, er_cyc, t0 + 1523);
        end
        checks++;
        if (en_cnt != 1523 || cap[1521] !== pat(8, 1513) || cap[1522] !== 8'h00) begin
            failures++;
            $display("FAIL ovs_bytes: en=%0d last_data=%h err_byte=%h required 1523 %h 00",
                     en_cnt, cap[1521], cap[1522], pat(8, 1513));
        end
    endtask

    task automatic test_reset_mid_frame();
        int t0, acc, idle;
        logic [31:0] exp_fcs, got_fcs;
        clear_mon();
        drive(64, 6, -1, 30, 1, acc);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        checks++;
        if (phy_tx_en !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: en=%b busy=%b ready=%b required 0 0 0", phy_tx_en, busy,
                     in_ready);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        clear_mon();
        t0 = cyc;
        drive(60, 7, -1, -1, 0, acc);
        wait_idle(idle);
        checks++;
        if (rise_q.size() != 1 || rise_q[0] != t0 + 1) begin
            failures++; $display("FAIL rst_restart: rise=%0d required %0d", rise_q[0], t0 + 1);
        end
        exp_fcs = model_fcs(7, 60);
        got_fcs = {cap[71], cap[70], cap[69], cap[68]};
        checks++;
        if (en_cnt != 72 || done_cnt != 1 || got_fcs !== exp_fcs) begin
            failures++;
            $display("FAIL rst_frame: en=%0d done=%0d fcs=%h required 72 1 %h", en_cnt, done_cnt,
                     got_fcs, exp_fcs);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_crc_unit();
        test_frame64();
        test_short_frame();
        test_back_to_back();
        test_underrun();
        test_oversize();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
